// File: rtl/mem_arb_if.sv
// Bus bundle for mem_arb: fetch port, data port and the shared memory port.
// Handshake: a requester raises *_req with stable address/data and holds it until
// its one-cycle *_ack; *_rdata and err are valid only while that ack is high.
// Memory side: mem_en stays high with stable controls until mem_rdy=1 is sampled.
interface mem_arb_if;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_ack;
  logic [31:0] if_rdata;
  logic        d_req;
  logic        d_we;
  logic [3:0]  d_be;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_ack;
  logic [31:0] d_rdata;
  logic        err;
  logic        mem_en;
  logic        mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_rdy;

  modport slave (
    input  if_req, if_addr, d_req, d_we, d_be, d_addr, d_wdata, mem_rdata, mem_rdy,
    output if_ack, if_rdata, d_ack, d_rdata, err,
    output mem_en, mem_we, mem_be, mem_addr, mem_wdata
  );

  modport master (
    output if_req, if_addr, d_req, d_we, d_be, d_addr, d_wdata, mem_rdata, mem_rdy,
    input  if_ack, if_rdata, d_ack, d_rdata, err,
    input  mem_en, mem_we, mem_be, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_arb.sv
// Two-port (fetch/data) arbiter onto one memory with a wait-cycle timeout.
// Define MEM_ARB_RR_EN for round-robin tie-break; default is fixed data-port priority.
module mem_arb #(
  parameter int unsigned WAIT_MAX = 15
) (
  input  logic       clk,
  input  logic       rst,
  mem_arb_if.slave   bus,
  output logic [1:0] o_dbg_state
);

  localparam logic [7:0] LP_WAIT_MAX = 8'(WAIT_MAX);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t      r_state;
  logic        r_owner_d;
  logic [7:0]  r_wait;
  logic        r_if_ack;
  logic        r_d_ack;
  logic        r_err;
  logic        r_mem_en;
  logic        r_mem_we;
  logic [3:0]  r_mem_be;
  logic [31:0] r_mem_addr;
  logic [31:0] r_mem_wdata;
  logic [31:0] r_if_rdata;
  logic [31:0] r_d_rdata;

  logic        w_any_req;
  logic        w_grant_d;
  logic        w_store;
  logic        w_done;
  logic [7:0]  w_wait_nxt;
  logic [31:0] w_rd_data;

  assign w_any_req = bus.if_req | bus.d_req;

`ifdef MEM_ARB_RR_EN
  logic r_prefer_d;
  assign w_grant_d = bus.d_req & (~bus.if_req | r_prefer_d);
`else
  assign w_grant_d = bus.d_req;
`endif

  assign w_store    = w_grant_d & bus.d_we;
  assign w_wait_nxt = r_wait + 8'd1;
  // A transaction ends on memory completion or when the wait budget runs out.
  assign w_done     = bus.mem_rdy | (w_wait_nxt == LP_WAIT_MAX);
  assign w_rd_data  = (bus.mem_rdy & ~r_mem_we) ? bus.mem_rdata : 32'd0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_owner_d   <= 1'b0;
      r_wait      <= 8'd0;
      r_if_ack    <= 1'b0;
      r_d_ack     <= 1'b0;
      r_err       <= 1'b0;
      r_mem_en    <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_be    <= 4'd0;
      r_mem_addr  <= 32'd0;
      r_mem_wdata <= 32'd0;
      r_if_rdata  <= 32'd0;
      r_d_rdata   <= 32'd0;
`ifdef MEM_ARB_RR_EN
      r_prefer_d  <= 1'b1;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          if (w_any_req) begin
            r_owner_d   <= w_grant_d;
            r_wait      <= 8'd0;
            r_mem_en    <= 1'b1;
            r_mem_we    <= w_store;
            r_mem_be    <= w_store ? bus.d_be : 4'hF;
            r_mem_addr  <= w_grant_d ? bus.d_addr : bus.if_addr;
            r_mem_wdata <= w_store ? bus.d_wdata : 32'd0;
            r_state     <= BUSY;
`ifdef MEM_ARB_RR_EN
            r_prefer_d  <= ~w_grant_d;
`endif
          end
        end
        BUSY: begin
          if (w_done) begin
            if (r_owner_d) begin
              r_d_ack   <= 1'b1;
              r_d_rdata <= w_rd_data;
            end else begin
              r_if_ack   <= 1'b1;
              r_if_rdata <= w_rd_data;
            end
            r_err       <= ~bus.mem_rdy;
            r_wait      <= 8'd0;
            r_mem_en    <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_be    <= 4'd0;
            r_mem_addr  <= 32'd0;
            r_mem_wdata <= 32'd0;
            r_state     <= RESP;
          end else begin
            r_wait <= w_wait_nxt;
          end
        end
        RESP: begin
          r_if_ack <= 1'b0;
          r_d_ack  <= 1'b0;
          r_err    <= 1'b0;
          r_state  <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.if_ack    = r_if_ack;
  assign bus.if_rdata  = r_if_rdata;
  assign bus.d_ack     = r_d_ack;
  assign bus.d_rdata   = r_d_rdata;
  assign bus.err       = r_err;
  assign bus.mem_en    = r_mem_en;
  assign bus.mem_we    = r_mem_we;
  assign bus.mem_be    = r_mem_be;
  assign bus.mem_addr  = r_mem_addr;
  assign bus.mem_wdata = r_mem_wdata;
  assign o_dbg_state   = r_state;

endmodule

// File: doc/mem_arb.md
MEM_ARB -- requirements
Module: mem_arb

Interface
REQ-001 Parameter WAIT_MAX, default 15: memory-wait cycles tolerated in BUSY before timeout; legal range 1..255.
REQ-002 clk  input  1  system clock; all state changes on its rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 if_req  input  1  fetch port request; held high until if_ack.
REQ-005 if_addr  input  32  fetch word address.
REQ-006 if_ack  output  1  one-cycle fetch completion pulse.
REQ-007 if_rdata  output  32  fetch read data; valid while if_ack=1.
REQ-008 d_req  input  1  data port request; held high until d_ack.
REQ-009 d_we  input  1  1=store, 0=load.
REQ-010 d_be  input  4  byte enables for stores (sb uses one lane, sw uses 4'b1111).
REQ-011 d_addr  input  32  data address.
REQ-012 d_wdata  input  32  store data.
REQ-013 d_ack  output  1  one-cycle data completion pulse.
REQ-014 d_rdata  output  32  load data; valid while d_ack=1.
REQ-015 err  output  1  high together with an ack when that transaction timed out.
REQ-016 mem_en / mem_we  output  1 each  shared memory strobe / write enable.
REQ-017 mem_be  output  4  byte enables (4'b1111 for fetches and loads).
REQ-018 mem_addr / mem_wdata  output  32 each  shared memory address / write data.
REQ-019 mem_rdata  input  32; mem_rdy  input  1  memory read data / completion.

Function
REQ-020 FSM states SHALL be IDLE, BUSY, RESP; all outputs SHALL be registered.
REQ-021 IDLE: if any request is high, the arbiter SHALL grant one, latch owner, address, we, be and wdata, and enter BUSY at the next edge; otherwise it SHALL stay in IDLE.
REQ-022 BUSY: mem_en=1 and mem_addr/mem_we/mem_be/mem_wdata SHALL hold the latched values for every BUSY cycle; mem_we=1 only for a granted data store.
REQ-023 BUSY with mem_rdy=1: the arbiter SHALL latch mem_rdata (zero for stores) into the owner's rdata, clear the wait counter, and enter RESP.
REQ-024 BUSY with mem_rdy=0: the 8-bit wait counter SHALL increment; when it equals WAIT_MAX, the arbiter SHALL enter RESP with err set and owner rdata forced to 0.
REQ-025 RESP: exactly the owner's ack SHALL be 1 for one cycle; mem_en SHALL be 0; next state IDLE.
REQ-026 Minimum latency: request seen in IDLE at cycle N, mem_rdy at N+1 -> ack at N+2; back-to-back grants every 3 cycles.
REQ-027 Requesters SHALL drop req in the ack cycle; a req still high in the following IDLE cycle SHALL be treated as a new request.
REQ-028 A req that drops while BUSY SHALL not abort the transaction; ack is still issued.
REQ-029 A req arriving during BUSY/RESP SHALL wait; no request is lost while held.
REQ-030 Simultaneous if_req and d_req in IDLE SHALL be resolved per REQ-036.
REQ-031 err SHALL be 0 except in a RESP cycle following a timeout.

Reset
REQ-032 rst SHALL immediately force state IDLE, wait counter 0, and all outputs (acks, err, mem_en, mem_we, mem_be, mem_addr, mem_wdata, rdata) to 0.
REQ-033 Reset during BUSY SHALL abandon the transaction with no ack; requesters reissue after reset.
REQ-034 With MEM_ARB_RR_EN, the priority pointer SHALL reset to favour the data port.

Configuration
REQ-035 Macro MEM_ARB_RR_EN SHALL select the tie-break policy.
REQ-036 Undefined: fixed priority, data port always wins ties. Defined: round-robin; on a tie, the port not granted most recently wins, and the pointer updates on every grant.

Verification
REQ-037 if_req=1, if_addr=0x0000_3000, mem_rdy=1 on first BUSY cycle, mem_rdata=0x3C01_1234 -> if_ack at cycle 2 with if_rdata=0x3C01_1234, err=0.
REQ-038 d_req=1, d_we=1, d_be=4'b0010, d_addr=0x10, d_wdata=0x0000_AB00, mem_rdy after 3 wait cycles -> mem_we=1, mem_be=4'b0010 for 4 BUSY cycles, then d_ack, d_rdata=0.
REQ-039 Both reqs held high for 4 transactions -> undefined: D,D,D,D; MEM_ARB_RR_EN: D,I,D,I.
REQ-040 WAIT_MAX=15, mem_rdy held 0 -> ack with err=1 and rdata=0 after 15 BUSY cycles, then IDLE.
REQ-041 rst pulsed in the 2nd BUSY cycle -> mem_en=0 immediately, no ack; the next request completes normally.
REQ-042 d_req dropped in the first BUSY cycle -> transaction completes, d_ack pulses once.
